// File: rtl/jam_perm_sequencer.sv
// Lexicographic permutation sequencer: offers all N! job assignments in order on a
// valid/ready handshake, stepping between them with the next-permutation algorithm.
module jam_perm_sequencer #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    output logic [N*IW-1:0] perm,
    output logic          perm_valid,
    input  logic          perm_ready,
    output logic          perm_last,
    output logic [CW-1:0] perm_idx,
    output logic          busy,
    output logic          done
);

    localparam int XW = $clog2(N);

    function automatic int unsigned fact(input int unsigned n);
        int unsigned f;
        f = 1;
        for (int unsigned k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    localparam logic [CW-1:0] LAST_IDX = CW'(fact(N) - 1);

    typedef enum logic [2:0] {IDLE, EMIT, FIND_I, FIND_J, SWAP, REV, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   pj [N];
    logic [XW-1:0]   i_q, j_q, l_q, r_q;
    logic            hs, found_i, found_j, rev_go;

    always_comb begin
        perm = '0;
        for (int unsigned k = 0; k < N; k++) perm[IW*k +: IW] = pj[k];
        perm_valid = (state == EMIT);
        perm_last  = perm_valid && (perm_idx == LAST_IDX);
        busy       = (state != IDLE) && (state != DONE);
        hs         = perm_valid && perm_ready;
        found_i    = pj[i_q] < pj[i_q + XW'(1)];
        found_j    = pj[j_q] > pj[i_q];
        rev_go     = l_q < r_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = EMIT;
            EMIT:       if (hs) state_nx = perm_last ? DONE : FIND_I;
            // Exhausting i is unreachable in practice; terminate rather than wrap.
            FIND_I:     if (found_i) state_nx = FIND_J;
                        else if (i_q == '0) state_nx = DONE;
            FIND_J:     if (found_j) state_nx = SWAP;
            SWAP:       state_nx = REV;
            REV:        if (!rev_go) state_nx = EMIT;
            default:    state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned k = 0; k < N; k++) pj[k] <= IW'(k);
            perm_idx <= '0;
            i_q      <= '0;
            j_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                for (int unsigned k = 0; k < N; k++) pj[k] <= IW'(k);
                perm_idx <= '0;
            end else begin
                case (state)
                    IDLE, DONE: if (start) begin
                        for (int unsigned k = 0; k < N; k++) pj[k] <= IW'(k);
                        perm_idx <= '0;
                    end
                    EMIT: if (hs) begin
                        if (perm_last) done <= 1'b1;
                        else           i_q  <= XW'(N - 2);
                    end
                    FIND_I: begin
                        if (found_i)         j_q <= XW'(N - 1);
                        else if (i_q != '0)  i_q <= i_q - XW'(1);
                    end
                    FIND_J: if (!found_j) j_q <= j_q - XW'(1);
                    SWAP: begin
                        pj[i_q] <= pj[j_q];
                        pj[j_q] <= pj[i_q];
                        l_q     <= i_q + XW'(1);
                        r_q     <= XW'(N - 1);
                    end
                    REV: begin
                        if (rev_go) begin
                            pj[l_q] <= pj[r_q];
                            pj[r_q] <= pj[l_q];
                            l_q     <= l_q + XW'(1);
                            r_q     <= r_q - XW'(1);
                        end else begin
                            perm_idx <= perm_idx + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jam_perm_sequencer.sv
// Bench for jam_perm_sequencer: four instances (N=3,4,6,8) checked every cycle against
// an index-unranking model, plus directed start/abort/reset scenarios.
module tb_jam_perm_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic st3 = 0, ab3 = 0, rd3 = 1, v3, l3, b3, d3;
    logic st4 = 0, ab4 = 0, rd4 = 1, v4, l4, b4, d4;
    logic st6 = 0, ab6 = 0, rd6 = 1, v6, l6, b6, d6;
    logic st8 = 0, ab8 = 0, rd8 = 1, v8, l8, b8, d8;
    logic [8:0]  p3;
    logic [11:0] p4;
    logic [17:0] p6;
    logic [23:0] p8;
    logic [15:0] x3, x4, x6, x8;

    jam_perm_sequencer #(.N(3), .IW(3), .CW(16)) u3 (.CLK(CLK), .RST(RST), .start(st3), .abort(ab3),
        .perm(p3), .perm_valid(v3), .perm_ready(rd3), .perm_last(l3), .perm_idx(x3), .busy(b3), .done(d3));
    jam_perm_sequencer #(.N(4), .IW(3), .CW(16)) u4 (.CLK(CLK), .RST(RST), .start(st4), .abort(ab4),
        .perm(p4), .perm_valid(v4), .perm_ready(rd4), .perm_last(l4), .perm_idx(x4), .busy(b4), .done(d4));
    jam_perm_sequencer #(.N(6), .IW(3), .CW(16)) u6 (.CLK(CLK), .RST(RST), .start(st6), .abort(ab6),
        .perm(p6), .perm_valid(v6), .perm_ready(rd6), .perm_last(l6), .perm_idx(x6), .busy(b6), .done(d6));
    jam_perm_sequencer #(.N(8), .IW(3), .CW(16)) u8 (.CLK(CLK), .RST(RST), .start(st8), .abort(ab8),
        .perm(p8), .perm_valid(v8), .perm_ready(rd8), .perm_last(l8), .perm_idx(x8), .busy(b8), .done(d8));

    int total = 0;
    int bad   = 0;
    int ns [4] = '{3, 4, 6, 8};
    bit          m_act [4];
    int          m_idx [4];
    bit          m_dexp [4];
    int          hs_cnt [4];
    int          done_cnt [4];
    bit          h_prev [4];
    logic [23:0] h_perm [4];
    logic [15:0] h_idx [4];
    logic        h_last [4];
    logic [8:0]  cap3 [$];
    logic [23:0] cap8 [$];
    bit          rnd4 = 0;

    function automatic int fact(input int n);
        int f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    function automatic logic [23:0] ident(input int n);
        logic [23:0] res = '0;
        for (int k = 0; k < n; k++) res |= 24'(k) << (3 * k);
        return res;
    endfunction

    // Lexicographic rank -> permutation via the factorial number system.
    function automatic logic [23:0] unrank(input int idx, input int n);
        int avail [8];
        int cnt = n;
        int rem = idx;
        int f, d;
        logic [23:0] res = '0;
        for (int k = 0; k < 8; k++) avail[k] = k;
        for (int k = 0; k < n; k++) begin
            f = fact(n - 1 - k);
            d = rem / f;
            rem = rem % f;
            res |= 24'(avail[d]) << (3 * k);
            for (int m = d; m < cnt - 1; m++) avail[m] = avail[m + 1];
            cnt--;
        end
        return res;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", nm, id, act, exp);
        end
    endtask

    task automatic check_inst(input int id, input logic v, input logic r, input logic lst,
                              input logic [23:0] p, input logic [15:0] ix,
                              input logic b, input logic d, input logic st, input logic ab);
        int n = ns[id];
        if (!RST) begin
            chk("rst_perm", id, p, ident(n));
            chk("rst_idx", id, ix, 0);
            chk("rst_valid", id, v, 0);
            chk("rst_last", id, lst, 0);
            chk("rst_busy", id, b, 0);
            chk("rst_done", id, d, 0);
            m_act[id] = 0; m_idx[id] = 0; m_dexp[id] = 0; h_prev[id] = 0;
            return;
        end
        if (d) done_cnt[id]++;
        chk("busy", id, b, m_act[id]);
        chk("done", id, d, m_dexp[id]);
        if (!m_act[id]) chk("valid_idle", id, v, 0);
        if (v) begin
            chk("perm", id, p, unrank(m_idx[id], n));
            chk("idx", id, ix, m_idx[id]);
            chk("last", id, lst, m_idx[id] == fact(n) - 1);
            if (h_prev[id]) begin
                chk("hold_perm", id, p, h_perm[id]);
                chk("hold_idx", id, ix, h_idx[id]);
                chk("hold_last", id, lst, h_last[id]);
            end
        end
        h_prev[id] = v && !r && !ab;
        h_perm[id] = p; h_idx[id] = ix; h_last[id] = lst;
        m_dexp[id] = 0;
        if (ab) begin
            m_act[id] = 0; m_idx[id] = 0;
        end else if (st && !m_act[id]) begin
            m_act[id] = 1; m_idx[id] = 0; hs_cnt[id] = 0; done_cnt[id] = 0;
            if (id == 0) cap3.delete();
            if (id == 3) cap8.delete();
        end else if (m_act[id] && v && r) begin
            hs_cnt[id]++;
            if (id == 0) cap3.push_back(p[8:0]);
            if (id == 3 && cap8.size() < 2) cap8.push_back(p);
            if (m_idx[id] == fact(n) - 1) begin
                m_act[id] = 0; m_dexp[id] = 1;
            end else begin
                m_idx[id]++;
            end
        end
    endtask

    always @(negedge CLK) begin
        check_inst(0, v3, rd3, l3, 24'(p3), x3, b3, d3, st3, ab3);
        check_inst(1, v4, rd4, l4, 24'(p4), x4, b4, d4, st4, ab4);
        check_inst(2, v6, rd6, l6, 24'(p6), x6, b6, d6, st6, ab6);
        check_inst(3, v8, rd8, l8, p8, x8, b8, d8, st8, ab8);
    end

    initial begin
        forever begin
            @(posedge CLK); #1;
            rd4 = rnd4 ? ($urandom_range(0, 9) >= 7) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    function automatic logic dsig(input int id);
        case (id)
            0: return d3;
            1: return d4;
            2: return d6;
            default: return d8;
        endcase
    endfunction

    task automatic pulse_start(input int id);
        case (id)
            0: st3 = 1;
            1: st4 = 1;
            2: st6 = 1;
            default: st8 = 1;
        endcase
        tick();
        st3 = 0; st4 = 0; st6 = 0; st8 = 0;
    endtask

    task automatic wait_done(input int id, input int budget);
        bit seen = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (dsig(id)) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", id, seen, 1);
    endtask

    int exp3 [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

    initial begin
        bit found;
        repeat (3) tick();
        RST = 1;
        tick();

        // N=3 full sweep, ready tied high
        pulse_start(0);
        wait_done(0, 200);
        tick();
        chk("hs3", 0, hs_cnt[0], 6);
        chk("done_cnt3", 0, done_cnt[0], 1);
        chk("busy3_after", 0, b3, 0);
        chk("cap3_size", 0, cap3.size(), 6);
        for (int r = 0; r < 6 && r < cap3.size(); r++)
            chk("seq3", 0, cap3[r], exp3[r][0] | (exp3[r][1] << 3) | (exp3[r][2] << 6));

        // N=4 with backpressure and a start pulse while busy
        rnd4 = 1;
        pulse_start(1);
        found = 0;
        for (int c = 0; c < 1000; c++) begin
            if (m_idx[1] == 5) begin found = 1; break; end
            tick();
        end
        chk("reach_idx5", 1, found, 1);
        pulse_start(1);
        wait_done(1, 4000);
        tick();
        chk("hs4", 1, hs_cnt[1], 24);
        chk("done_cnt4", 1, done_cnt[1], 1);

        // N=4 abort coincident with the handshake of idx 10
        rnd4 = 0;
        repeat (2) tick();
        pulse_start(1);
        found = 0;
        for (int c = 0; c < 1000; c++) begin
            if (v4 && x4 == 16'd10) begin found = 1; break; end
            tick();
        end
        chk("reach_idx10", 1, found, 1);
        ab4 = 1;
        tick();
        ab4 = 0;
        chk("abort_valid", 1, v4, 0);
        chk("abort_busy", 1, b4, 0);
        chk("abort_perm", 1, p4, 12'o3210);
        repeat (5) tick();
        chk("abort_nodone", 1, done_cnt[1], 0);
        pulse_start(1);
        chk("restart_idx", 1, x4, 0);
        wait_done(1, 1000);
        tick();
        chk("hs4_restart", 1, hs_cnt[1], 24);

        // N=6 full sweep
        pulse_start(2);
        wait_done(2, 20000);
        tick();
        chk("hs6", 2, hs_cnt[2], 720);
        chk("done_cnt6", 2, done_cnt[2], 1);

        // N=8 prefix, then abort
        pulse_start(3);
        found = 0;
        for (int c = 0; c < 20000; c++) begin
            if (hs_cnt[3] >= 1500) begin found = 1; break; end
            tick();
        end
        chk("reach_hs8", 3, found, 1);
        chk("cap8_size", 3, cap8.size(), 2);
        if (cap8.size() == 2) begin
            chk("first8", 3, cap8[0], 24'o76543210);
            chk("second8", 3, cap8[1], 24'o67543210);
        end
        ab8 = 1;
        tick();
        ab8 = 0;
        chk("abort8_busy", 3, b8, 0);
        chk("abort8_valid", 3, v8, 0);

        // N=3: asynchronous reset in the middle of REV after the first handshake
        pulse_start(0);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (v3 && x3 == 16'd0) begin found = 1; break; end
            tick();
        end
        chk("reach_emit0", 0, found, 1);
        repeat (4) tick();
        #2 RST = 0;
        #1;
        chk("arst_busy", 0, b3, 0);
        chk("arst_valid", 0, v3, 0);
        chk("arst_perm", 0, p3, 9'o210);
        chk("arst_idx", 0, x3, 0);
        chk("arst_done", 0, d3, 0);
        repeat (2) tick();
        RST = 1;
        tick();
        pulse_start(0);
        wait_done(0, 200);
        tick();
        chk("hs3_after_rst", 0, hs_cnt[0], 6);
        chk("done_cnt3_after_rst", 0, done_cnt[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
